// File: rtl/shift_add_multiplier_if.sv
// Handshake/operand bundle for shift_add_multiplier; r_err exists only when REM_CHECK_EN is defined.
// The requester holds the master modport; the multiplier holds the slave modport.
interface shift_add_multiplier_if #(
    parameter int N = 4
);
    logic           start;
    logic [N-1:0]   q;
    logic [N-1:0]   d;
    logic [N:0]     r;
    logic           busy;
    logic           done;
    logic [2*N:0]   p;
`ifdef REM_CHECK_EN
    logic           r_err;

    modport master (
        output start, q, d, r,
        input  busy, done, p, r_err
    );

    modport slave (
        input  start, q, d, r,
        output busy, done, p, r_err
    );
`else
    modport master (
        output start, q, d, r,
        input  busy, done, p
    );

    modport slave (
        input  start, q, d, r,
        output busy, done, p
    );
`endif
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier computing p = q*d + r, one partial product per clock.
// Optional macro REM_CHECK_EN adds the registered remainder range flag r_err = (r >= d).
//
// state | meaning
// IDLE  | waiting for start; operands sampled on the accepting edge
// RUN   | N shift-and-add iterations
// DONE  | one-cycle done pulse, p valid
module shift_add_multiplier #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_add_multiplier_if.slave bus
);
    localparam int PW = 2 * N + 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mcand;
    logic [N-1:0]    mplier;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   p_reg;
    logic [PW-1:0]   acc_sum;
    logic            load;
    logic            last_iter;
    logic            busy;
    logic            done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(N - 1)) begin
                    last_iter = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The sum is formed combinationally so the last iteration can feed p directly.
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            p_reg  <= '0;
        end else if (load) begin
            acc    <= {{(PW - N - 1){1'b0}}, bus.r};
            mcand  <= {{(PW - N){1'b0}}, bus.d};
            mplier <= bus.q;
            cnt    <= '0;
        end else if (state_q == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last_iter) begin
                p_reg <= acc_sum;
            end
        end
    end

`ifdef REM_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (load) begin
            r_err <= (bus.r >= {1'b0, bus.d});
        end
    end

    assign bus.r_err = r_err;
`endif

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.p    = p_reg;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed and random operands against q*d + r.
// Build with REM_CHECK_EN defined to also check r_err.
module tb_shift_add_multiplier;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    shift_add_multiplier_if #(.N(N)) bus ();

    shift_add_multiplier #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed still running, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input int qv, input int dv, input int rv);
        return 32'(qv * dv + rv);
    endfunction

    // One full transaction; operands are scrambled right after acceptance to prove they were captured.
    task automatic run_op(input int qv, input int dv, input int rv);
        logic [31:0] exp;
        logic [31:0] p_before;
        exp      = model(qv, dv, rv);
        p_before = 32'(bus.p);
        @(negedge clk);
        bus.start = 1'b1;
        bus.q     = N'(qv);
        bus.d     = N'(dv);
        bus.r     = (N + 1)'(rv);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.q     = N'($urandom);
        bus.d     = N'($urandom);
        bus.r     = (N + 1)'($urandom);
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        chk("done_after_accept", 32'(bus.done), 32'd0);
`ifdef REM_CHECK_EN
        chk("r_err", 32'(bus.r_err), (rv >= dv) ? 32'd1 : 32'd0);
`endif
        for (int i = 1; i < N; i++) begin
            @(posedge clk);
            #1;
            chk("done_early", 32'(bus.done), 32'd0);
            chk("p_stable_in_run", 32'(bus.p), p_before);
        end
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("busy_in_done", 32'(bus.busy), 32'd1);
        chk("p_result", 32'(bus.p), exp);
        @(posedge clk);
        #1;
        chk("done_cleared", 32'(bus.done), 32'd0);
        chk("busy_cleared", 32'(bus.busy), 32'd0);
        chk("p_held", 32'(bus.p), exp);
    endtask

    initial begin
        int qa, da, ra, qb, db, rb;
        int first_done, second_done;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.q     = '0;
        bus.d     = '0;
        bus.r     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_p", 32'(bus.p), 32'd0);
`ifdef REM_CHECK_EN
        chk("reset_r_err", 32'(bus.r_err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op(13, 3, 2);
        run_op(15, 15, 31);
        run_op(9, 0, 5);
        run_op(0, 11, 17);
        run_op(2, 3, 4);
        run_op(2, 3, 2);

        for (int k = 0; k < 10; k++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
        end

        // start held high; operands changed mid-run
        qa = 11; da = 14; ra = 9;
        qb = 6;  db = 7;  rb = 30;
        @(negedge clk);
        bus.start = 1'b1;
        bus.q = N'(qa); bus.d = N'(da); bus.r = (N + 1)'(ra);
        @(posedge clk);
        #1;
        bus.q = N'(qb); bus.d = N'(db); bus.r = (N + 1)'(rb);
        first_done  = -1;
        second_done = -1;
        for (int c = 1; c <= 3 * (N + 2); c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                if (first_done < 0) begin
                    first_done = c;
                    chk("held_p_first", 32'(bus.p), model(qa, da, ra));
                end else if (second_done < 0) begin
                    second_done = c;
                    chk("held_p_second", 32'(bus.p), model(qb, db, rb));
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        chk("held_first_latency", 32'(first_done), 32'(N));
        chk("held_gap", 32'(second_done - first_done), 32'(N + 2));
        chk("held_idle_after", 32'(bus.busy), 32'd0);

        // reset during the second RUN cycle discards the operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.q = N'(7); bus.d = N'(5); bus.r = (N + 1)'(1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrun_rst_busy", 32'(bus.busy), 32'd0);
        chk("midrun_rst_done", 32'(bus.done), 32'd0);
        chk("midrun_rst_p", 32'(bus.p), 32'd0);
        for (int c = 0; c < N + 3; c++) begin
            @(posedge clk);
            #1;
            chk("no_done_after_rst", 32'(bus.done), 32'd0);
        end
        run_op(7, 5, 1);

        // rst beats start on the same edge
        @(negedge clk);
        bus.start = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wins_busy", 32'(bus.busy), 32'd0);
        chk("rst_wins_p", 32'(bus.p), 32'd0);
        bus.start = 1'b0;
        rst       = 1'b0;
        run_op(12, 10, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
